dense_bias_argmax: RTL and testbench

- Final stage of the dense (fully connected) layer.
- Accepts one accumulated dot-product per output neuron as a valid/ready stream.
- Fetches the matching bias word from the dense bias lookup table, adds it with saturation, and emits each biased logit.
- Tracks the running maximum and presents the winning class index (digit 0-9) once per frame, held until acknowledged.

---
 rtl/dense_pkg.sv | 22 ++
 rtl/dense_bias_argmax_if.sv | 35 +++
 rtl/sat_add_signed.sv | 24 ++
 rtl/dense_bias_argmax.sv | 109 ++++++++++
 tb/tb_dense_bias_argmax.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/dense_pkg.sv
// Shared definitions for the dense-layer output stage.
// Provides word/index widths, frame length, saturation limits and the
// state encoding used by dense_bias_argmax.
package dense_pkg;

    localparam int unsigned WORD_SIZE   = 32;
    localparam int unsigned LENGTH_SIZE = 10;
    localparam int unsigned ADR_SIZE    = 4;

    // Two's complement clamp limits for a WORD_SIZE logit.
    localparam logic [WORD_SIZE-1:0] SAT_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic [WORD_SIZE-1:0] SAT_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

    // Index of the final neuron in a frame.
    localparam logic [ADR_SIZE-1:0] LAST_IDX = ADR_SIZE'(LENGTH_SIZE - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

endpackage

// File: rtl/dense_bias_argmax_if.sv
// Bus bundle for dense_bias_argmax.
// Signals: accumulator stream (acc_valid/acc_ready/acc_data), bias LUT
// lookup (bias_adr/bias_data), per-neuron logit pulse (logit_*), and the
// held per-frame classification result (class_*, class_ack).
// slave  : the dense_bias_argmax block.
// master : the environment (accumulator source, bias LUT, result consumer).
interface dense_bias_argmax_if;
    import dense_pkg::*;

    logic                 acc_valid;
    logic                 acc_ready;
    logic [WORD_SIZE-1:0] acc_data;
    logic [ADR_SIZE-1:0]  bias_adr;
    logic [WORD_SIZE-1:0] bias_data;
    logic                 logit_valid;
    logic [WORD_SIZE-1:0] logit_data;
    logic [ADR_SIZE-1:0]  logit_idx;
    logic                 class_valid;
    logic [ADR_SIZE-1:0]  class_idx;
    logic [WORD_SIZE-1:0] class_max;
    logic                 class_ack;

    modport slave (
        input  acc_valid, acc_data, bias_data, class_ack,
        output acc_ready, bias_adr, logit_valid, logit_data, logit_idx,
               class_valid, class_idx, class_max
    );

    modport master (
        output acc_valid, acc_data, bias_data, class_ack,
        input  acc_ready, bias_adr, logit_valid, logit_data, logit_idx,
               class_valid, class_idx, class_max
    );

endinterface

// File: rtl/sat_add_signed.sv
// Combinational saturating adder for signed two's complement words.
// Ports: i_a, i_b (WIDTH-bit signed operands), o_sum_c (clamped sum).
module sat_add_signed #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_sum_c
);

    logic [WIDTH:0] w_wide;

    // One guard bit: overflow shows up as the top two bits disagreeing,
    // and the guard bit then gives the true sign of the result.
    always_comb begin
        w_wide  = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};
        o_sum_c = w_wide[WIDTH-1:0];
        if (w_wide[WIDTH] != w_wide[WIDTH-1]) begin
            o_sum_c = w_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dense_bias_argmax.sv
// Dense-layer output stage: adds the per-neuron bias to each accumulated
// dot product with saturation, emits each logit as a one-cycle pulse, and
// tracks the argmax over a frame of LENGTH_SIZE neurons. The winning class
// is held on class_* until class_ack; new beats are back-pressured meanwhile.
// Ports: clk, rst (async active-high), bus (dense_bias_argmax_if.slave).
module dense_bias_argmax
    import dense_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    dense_bias_argmax_if.slave        bus
);

    state_t                r_state;
    logic [ADR_SIZE-1:0]   r_idx;
    logic [WORD_SIZE-1:0]  r_max;
    logic [ADR_SIZE-1:0]   r_argidx;
    logic                  r_acc_ready;
    logic                  r_logit_valid;
    logic [WORD_SIZE-1:0]  r_logit_data;
    logic [ADR_SIZE-1:0]   r_logit_idx;
    logic                  r_class_valid;
    logic [ADR_SIZE-1:0]   r_class_idx;
    logic [WORD_SIZE-1:0]  r_class_max;

    logic                  w_accept;
    logic [WORD_SIZE-1:0]  w_sum;
    logic                  w_take;
    logic [WORD_SIZE-1:0]  w_max_nxt;
    logic [ADR_SIZE-1:0]   w_arg_nxt;

    sat_add_signed #(
        .WIDTH   (WORD_SIZE)
    ) u_sat_add (
        .i_a     (bus.acc_data),
        .i_b     (bus.bias_data),
        .o_sum_c (w_sum)
    );

    assign w_accept = bus.acc_valid && r_acc_ready;

    // Neuron 0 always seeds the max; afterwards only a strictly larger
    // logit wins, so ties keep the lowest index.
    assign w_take    = (r_idx == '0) || ($signed(w_sum) > $signed(r_max));
    assign w_max_nxt = w_take ? w_sum : r_max;
    assign w_arg_nxt = w_take ? r_idx : r_argidx;

    // Frame FSM, neuron counter, argmax tracking and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_idx         <= '0;
            r_max         <= '0;
            r_argidx      <= '0;
            r_acc_ready   <= 1'b1;
            r_logit_valid <= 1'b0;
            r_logit_data  <= '0;
            r_logit_idx   <= '0;
            r_class_valid <= 1'b0;
            r_class_idx   <= '0;
            r_class_max   <= '0;
        end else begin
            r_logit_valid <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        r_logit_valid <= 1'b1;
                        r_logit_data  <= w_sum;
                        r_logit_idx   <= r_idx;
                        r_max         <= w_max_nxt;
                        r_argidx      <= w_arg_nxt;
                        if (r_idx == LAST_IDX) begin
                            // Result includes the last neuron, so publish
                            // the post-update argmax alongside its logit.
                            r_idx         <= '0;
                            r_state       <= S_DONE;
                            r_acc_ready   <= 1'b0;
                            r_class_valid <= 1'b1;
                            r_class_idx   <= w_arg_nxt;
                            r_class_max   <= w_max_nxt;
                        end else begin
                            r_idx <= r_idx + ADR_SIZE'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (bus.class_ack) begin
                        r_class_valid <= 1'b0;
                        r_acc_ready   <= 1'b1;
                        r_state       <= S_RUN;
                    end
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    assign bus.acc_ready   = r_acc_ready;
    assign bus.bias_adr    = r_idx;
    assign bus.logit_valid = r_logit_valid;
    assign bus.logit_data  = r_logit_data;
    assign bus.logit_idx   = r_logit_idx;
    assign bus.class_valid = r_class_valid;
    assign bus.class_idx   = r_class_idx;
    assign bus.class_max   = r_class_max;

endmodule

// File: tb/tb_dense_bias_argmax.sv
// Self-checking bench for dense_bias_argmax: directed frame table plus
// randomized frames checked against a plain-arithmetic reference model.
module tb_dense_bias_argmax;
    import dense_pkg::*;

    typedef struct packed {
        logic [9:0][31:0] acc;
        logic [9:0][31:0] bias;
        logic [3:0]       exp_idx;
        logic [31:0]      exp_max;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] bias_lut [16];
    vec_t        tbl [5];
    logic [3:0]  gi;
    logic [31:0] gm;

    dense_bias_argmax_if bus_if();

    always_comb bus_if.bias_data = bias_lut[bus_if.bias_adr];

    dense_bias_argmax dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] sat_ref(input logic [31:0] a, input logic [31:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return 32'(s);
    endfunction

    function automatic void frame_ref(input logic [9:0][31:0] acc, input logic [9:0][31:0] bias,
                                      output logic [9:0][31:0] lg, output int win);
        win = 0;
        for (int i = 0; i < 10; i++) lg[i] = sat_ref(acc[i], bias[i]);
        for (int i = 1; i < 10; i++)
            if ($signed(lg[i]) > $signed(lg[win])) win = i;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(3))
            0:       return $urandom;
            1:       return 32'($urandom_range(200)) - 32'd100;
            2:       return 32'h7FFF_FF00 + 32'($urandom_range(255));
            default: return 32'h8000_0000 + 32'($urandom_range(255));
        endcase
    endfunction

    // Stream one frame (starting at a negedge), check every logit pulse,
    // then hold the result for ack_delay cycles before acknowledging.
    task automatic run_frame(input logic [9:0][31:0] acc, input logic [9:0][31:0] bias,
                             input int gap_pct, input int ack_delay,
                             input logic hold_valid, input logic [31:0] hold_data,
                             output logic [3:0] got_idx, output logic [31:0] got_max);
        logic [9:0][31:0] lg;
        int win;
        frame_ref(acc, bias, lg, win);
        for (int k = 0; k < 10; k++) bias_lut[k] = bias[k];
        for (int i = 0; i < 10; i++) begin
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                bus_if.acc_valid = 1'b0;
                bus_if.acc_data  = $urandom;
                bus_if.class_ack = 1'($urandom_range(1));
                @(negedge clk);
                chk("idle_logit_valid", 32'(bus_if.logit_valid), 32'd0);
                chk("idle_class_valid", 32'(bus_if.class_valid), 32'd0);
            end
            chk("bias_adr", 32'(bus_if.bias_adr), 32'(i));
            chk("acc_ready", 32'(bus_if.acc_ready), 32'd1);
            bus_if.acc_valid = 1'b1;
            bus_if.acc_data  = acc[i];
            bus_if.class_ack = 1'($urandom_range(1));
            @(negedge clk);
            chk("logit_valid", 32'(bus_if.logit_valid), 32'd1);
            chk("logit_data", bus_if.logit_data, lg[i]);
            chk("logit_idx", 32'(bus_if.logit_idx), 32'(i));
            chk("class_valid", 32'(bus_if.class_valid), (i == 9) ? 32'd1 : 32'd0);
        end
        got_idx = bus_if.class_idx;
        got_max = bus_if.class_max;
        for (int d = 0; d < ack_delay; d++) begin
            bus_if.acc_valid = hold_valid;
            bus_if.acc_data  = hold_data;
            bus_if.class_ack = 1'b0;
            chk("bp_acc_ready", 32'(bus_if.acc_ready), 32'd0);
            chk("bp_class_valid", 32'(bus_if.class_valid), 32'd1);
            chk("bp_class_idx", 32'(bus_if.class_idx), 32'(got_idx));
            chk("bp_class_max", bus_if.class_max, got_max);
            chk("bp_bias_adr", 32'(bus_if.bias_adr), 32'd0);
            if (d > 0) chk("bp_logit_valid", 32'(bus_if.logit_valid), 32'd0);
            @(negedge clk);
        end
        bus_if.acc_valid = hold_valid;
        bus_if.acc_data  = hold_data;
        bus_if.class_ack = 1'b1;
        @(negedge clk);
        bus_if.class_ack = 1'b0;
        chk("ack_class_valid", 32'(bus_if.class_valid), 32'd0);
        chk("ack_acc_ready", 32'(bus_if.acc_ready), 32'd1);
        chk("ack_bias_adr", 32'(bus_if.bias_adr), 32'd0);
        chk("ack_logit_valid", 32'(bus_if.logit_valid), 32'd0);
    endtask

    initial begin
        logic [9:0][31:0] ra;
        logic [9:0][31:0] rb;
        logic [9:0][31:0] rlg;
        int rwin;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_if.acc_valid = 1'b0;
        bus_if.acc_data  = '0;
        bus_if.class_ack = 1'b0;
        for (int k = 0; k < 16; k++) bias_lut[k] = 32'hDEAD_0000 + 32'(k);

        // Directed frame table.
        for (int t = 0; t < 5; t++) tbl[t] = '0;
        tbl[0].acc[0] = 32'd5; tbl[0].acc[1] = 32'd1; tbl[0].acc[2] = 32'd9;
        tbl[0].acc[3] = 32'd3; tbl[0].acc[9] = 32'd2;
        tbl[0].exp_idx = 4'd2; tbl[0].exp_max = 32'd9;
        for (int i = 0; i < 10; i++) tbl[1].bias[i] = 32'(i) * 32'h0010_0000;
        tbl[1].exp_idx = 4'd9; tbl[1].exp_max = 32'h0090_0000;
        tbl[2].acc[0] = 32'h7FFF_FFF0; tbl[2].bias[0] = 32'h0000_0100;
        tbl[2].acc[1] = 32'h8000_0010; tbl[2].bias[1] = 32'hFFFF_FF00;
        tbl[2].exp_idx = 4'd0; tbl[2].exp_max = 32'h7FFF_FFFF;
        for (int i = 0; i < 10; i++) tbl[3].acc[i] = 32'hFFFF_FFF9;
        tbl[3].exp_idx = 4'd0; tbl[3].exp_max = 32'hFFFF_FFF9;
        for (int i = 0; i < 10; i++) tbl[4].acc[i] = 32'hFFFF_FF9C;
        tbl[4].acc[3] = 32'd40; tbl[4].bias[3] = 32'd10; tbl[4].acc[6] = 32'd50;
        tbl[4].exp_idx = 4'd3; tbl[4].exp_max = 32'd50;

        repeat (3) @(negedge clk);
        chk("rst_logit_valid", 32'(bus_if.logit_valid), 32'd0);
        chk("rst_logit_data", bus_if.logit_data, 32'd0);
        chk("rst_logit_idx", 32'(bus_if.logit_idx), 32'd0);
        chk("rst_class_valid", 32'(bus_if.class_valid), 32'd0);
        chk("rst_class_idx", 32'(bus_if.class_idx), 32'd0);
        chk("rst_class_max", bus_if.class_max, 32'd0);
        chk("rst_acc_ready", 32'(bus_if.acc_ready), 32'd1);
        chk("rst_bias_adr", 32'(bus_if.bias_adr), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            run_frame(tbl[t].acc, tbl[t].bias, 0, (t == 0) ? 5 : 1, 1'b1,
                      tbl[(t + 1) % 5].acc[0], gi, gm);
            chk("tbl_class_idx", 32'(gi), 32'(tbl[t].exp_idx));
            chk("tbl_class_max", gm, tbl[t].exp_max);
        end

        // Asynchronous reset between clock edges after four beats.
        for (int k = 0; k < 10; k++) bias_lut[k] = '0;
        for (int i = 0; i < 4; i++) begin
            bus_if.acc_valid = 1'b1;
            bus_if.acc_data  = 32'h4000_0000;
            @(negedge clk);
        end
        bus_if.acc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_logit_valid", 32'(bus_if.logit_valid), 32'd0);
        chk("mid_rst_logit_data", bus_if.logit_data, 32'd0);
        chk("mid_rst_logit_idx", 32'(bus_if.logit_idx), 32'd0);
        chk("mid_rst_class_valid", 32'(bus_if.class_valid), 32'd0);
        chk("mid_rst_acc_ready", 32'(bus_if.acc_ready), 32'd1);
        chk("mid_rst_bias_adr", 32'(bus_if.bias_adr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            ra[i] = 32'hFFFF_FFEC;
            rb[i] = '0;
        end
        ra[5] = 32'hFFFF_FFFD;
        run_frame(ra, rb, 0, 2, 1'b0, 32'd0, gi, gm);
        chk("post_rst_class_idx", 32'(gi), 32'd5);
        chk("post_rst_class_max", gm, 32'hFFFF_FFFD);

        // Randomized frames against the reference model.
        for (int f = 0; f < 25; f++) begin
            for (int i = 0; i < 10; i++) begin
                ra[i] = rand_word();
                rb[i] = rand_word();
            end
            frame_ref(ra, rb, rlg, rwin);
            run_frame(ra, rb, 30, int'($urandom_range(3)), 1'($urandom_range(1)),
                      $urandom, gi, gm);
            chk("rnd_class_idx", 32'(gi), 32'(rwin));
            chk("rnd_class_max", gm, rlg[rwin]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
